// File: rtl/fetch_seq_if.sv
// Fetch-stage bundle: instruction memory request/ack bus, redirect inputs
// and the IF/ID slot outputs toward decode.
interface fetch_seq_if;
   logic        stall;
   logic        br_valid;
   logic [31:0] br_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        misalign;

   modport master (
      input  stall, br_valid, br_target, imem_ack, imem_rdata,
      output imem_req, imem_addr, if_valid, if_pc, if_instr, misalign
   );

   modport slave (
      output stall, br_valid, br_target, imem_ack, imem_rdata,
      input  imem_req, imem_addr, if_valid, if_pc, if_instr, misalign
   );
endinterface

// File: rtl/fetch_seq.sv
// Instruction fetch sequencer: one outstanding memory request, a single
// IF/ID slot, and branch redirects that squash in-flight data.
module fetch_seq #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter logic [31:0] PC_STEP  = 32'd4
) (
   input  logic        clk,
   input  logic        rst_n,
   fetch_seq_if.master bus
);

   typedef enum logic [1:0] {ST_BOOT, ST_REQ, ST_DROP} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] old_q, old_d;
   logic [31:0] if_pc_q, if_pc_d;
   logic [31:0] if_instr_q, if_instr_d;
   logic        if_valid_q, if_valid_d;
   logic        misalign_q, misalign_d;

   logic        free;
   logic        req;
   logic [31:0] br_pc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_BOOT;
         pc_q       <= RESET_PC;
         old_q      <= 32'd0;
         if_pc_q    <= 32'd0;
         if_instr_q <= 32'd0;
         if_valid_q <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         old_q      <= old_d;
         if_pc_q    <= if_pc_d;
         if_instr_q <= if_instr_d;
         if_valid_q <= if_valid_d;
         misalign_q <= misalign_d;
      end
   end

   always_comb begin
      free  = !if_valid_q || !bus.stall;
      req   = (state_q == ST_DROP) || ((state_q == ST_REQ) && free);
      br_pc = {bus.br_target[31:2], 2'b00};

      state_d    = state_q;
      pc_d       = pc_q;
      old_d      = old_q;
      if_pc_d    = if_pc_q;
      if_instr_d = if_instr_q;
      // A slot consumed by decode this cycle empties unless refilled below.
      if_valid_d = if_valid_q && bus.stall;
      misalign_d = bus.br_valid && (bus.br_target[1:0] != 2'b00);

      case (state_q)
         ST_BOOT: begin
            state_d = ST_REQ;
            if (bus.br_valid) begin
               pc_d       = br_pc;
               if_valid_d = 1'b0;
            end
         end
         ST_REQ: begin
            if (bus.br_valid) begin
               pc_d       = br_pc;
               if_valid_d = 1'b0;
               // Request already on the bus must still complete; its data is squashed.
               if (req && !bus.imem_ack) begin
                  state_d = ST_DROP;
                  old_d   = pc_q;
               end
            end else if (req && bus.imem_ack) begin
               if_pc_d    = pc_q;
               if_instr_d = bus.imem_rdata;
               if_valid_d = 1'b1;
               pc_d       = pc_q + PC_STEP;
            end
         end
         ST_DROP: begin
            if (bus.br_valid) begin
               pc_d       = br_pc;
               if_valid_d = 1'b0;
            end
            if (bus.imem_ack) begin
               state_d = ST_REQ;
            end
         end
         default: state_d = ST_BOOT;
      endcase
   end

   assign bus.imem_req  = req;
   assign bus.imem_addr = (state_q == ST_DROP) ? old_q : pc_q;
   assign bus.if_valid  = if_valid_q;
   assign bus.if_pc     = if_pc_q;
   assign bus.if_instr  = if_instr_q;
   assign bus.misalign  = misalign_q;

endmodule

// File: tb/tb_fetch_seq.sv
// Directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a behavioural fetch model.
module tb_fetch_seq;

   localparam logic [31:0] KEY      = 32'h5A5A_C3C3;
   localparam logic [31:0] RESET_PC = 32'h0000_3000;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_bad;

   fetch_seq_if bus();

   fetch_seq #(.RESET_PC(RESET_PC), .PC_STEP(32'd4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Memory returns a word derived from its address so leaked data is visible.
   assign bus.imem_rdata = bus.imem_addr ^ KEY;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: next fetch PC, an optional squashed request still
   // owed by memory, and the decode slot.
   bit          m_boot;
   bit          m_drop;
   bit          m_v;
   bit          m_mis;
   logic [31:0] m_pc, m_old, m_ipc, m_instr;
   bit          u_req;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_boot = 1; m_drop = 0; m_v = 0; m_mis = 0;
         m_pc = RESET_PC; m_old = 0; m_ipc = 0; m_instr = 0;
      end else begin
         u_req = !m_boot && (m_drop || !m_v || !bus.stall);
         m_mis = bus.br_valid && (bus.br_target[1:0] != 2'b00);
         if (bus.br_valid) begin
            if (u_req && !bus.imem_ack) begin
               if (!m_drop) m_old = m_pc;
               m_drop = 1;
            end else begin
               m_drop = 0;
            end
            m_pc = bus.br_target & 32'hFFFF_FFFC;
            m_v  = 0;
         end else if (m_drop) begin
            if (bus.imem_ack) m_drop = 0;
            if (!bus.stall) m_v = 0;
         end else if (u_req && bus.imem_ack) begin
            m_ipc   = m_pc;
            m_instr = m_pc ^ KEY;
            m_v     = 1;
            m_pc    = m_pc + 32'd4;
         end else if (!bus.stall) begin
            m_v = 0;
         end
         m_boot = 0;
      end
   end

   always @(negedge clk) begin
      automatic bit e_req = !m_boot && (m_drop || !m_v || !bus.stall);
      chk("imem_req", {31'd0, bus.imem_req}, {31'd0, e_req});
      if (e_req) chk("imem_addr", bus.imem_addr, m_drop ? m_old : m_pc);
      chk("if_valid", {31'd0, bus.if_valid}, {31'd0, m_v});
      chk("if_pc", bus.if_pc, m_ipc);
      chk("if_instr", bus.if_instr, m_instr);
      chk("misalign", {31'd0, bus.misalign}, {31'd0, m_mis});
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic slot(input string name, input logic v, input logic [31:0] pc);
      chk({name, ".valid"}, {31'd0, bus.if_valid}, {31'd0, v});
      if (v) begin
         chk({name, ".pc"}, bus.if_pc, pc);
         chk({name, ".instr"}, bus.if_instr, pc ^ KEY);
      end
      $display("step %s: req=%0b addr=%h valid=%0b pc=%h", name, bus.imem_req,
               bus.imem_addr, bus.if_valid, bus.if_pc);
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst_n = 1'b0;
      bus.stall = 1'b0;
      bus.br_valid = 1'b0;
      bus.br_target = 32'd0;
      bus.imem_ack = 1'b1;

      cyc();
      chk("rst.req", {31'd0, bus.imem_req}, 32'd0);
      chk("rst.misalign", {31'd0, bus.misalign}, 32'd0);
      chk("rst.if_pc", bus.if_pc, 32'd0);
      chk("rst.if_instr", bus.if_instr, 32'd0);
      slot("rst", 1'b0, 32'd0);
      rst_n = 1'b1;

      // Sequential fetch, one per cycle.
      cyc(); chk("seq0.addr", bus.imem_addr, 32'h3000); chk("seq0.req", {31'd0, bus.imem_req}, 32'd1);
      cyc(); chk("seq1.addr", bus.imem_addr, 32'h3004); slot("seq1", 1'b1, 32'h3000);
      cyc(); chk("seq2.addr", bus.imem_addr, 32'h3008); slot("seq2", 1'b1, 32'h3004);

      // Stall holds the slot and the request stays off.
      bus.stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #0 chk("stall.req", {31'd0, bus.imem_req}, 32'd0);
         slot("stall", 1'b1, 32'h3004);
         cyc();
      end
      bus.stall = 1'b0;
      #0 chk("unstall.addr", bus.imem_addr, 32'h3008);
      cyc(); slot("unstall", 1'b1, 32'h3008); chk("unstall.next", bus.imem_addr, 32'h300C);

      // Redirect in the same cycle as an ack.
      bus.br_valid = 1'b1; bus.br_target = 32'h0000_4000;
      cyc(); bus.br_valid = 1'b0;
      slot("br_ack", 1'b0, 32'd0); chk("br_ack.addr", bus.imem_addr, 32'h4000);
      cyc(); slot("br_ack2", 1'b1, 32'h4000);

      // Redirect while ack is withheld: old address stays on the bus.
      bus.imem_ack = 1'b0; bus.br_valid = 1'b1; bus.br_target = 32'h0000_4000;
      cyc(); bus.br_valid = 1'b0;
      slot("drop0", 1'b0, 32'd0); chk("drop0.addr", bus.imem_addr, 32'h4004);
      cyc(); chk("drop1.addr", bus.imem_addr, 32'h4004); chk("drop1.req", {31'd0, bus.imem_req}, 32'd1);
      bus.imem_ack = 1'b1;
      cyc(); slot("drop2", 1'b0, 32'd0); chk("drop2.addr", bus.imem_addr, 32'h4000);
      cyc(); slot("drop3", 1'b1, 32'h4000);

      // Misaligned target.
      bus.br_valid = 1'b1; bus.br_target = 32'h0000_4002;
      cyc(); bus.br_valid = 1'b0;
      chk("mis.pulse", {31'd0, bus.misalign}, 32'd1); chk("mis.addr", bus.imem_addr, 32'h4000);
      cyc(); chk("mis.end", {31'd0, bus.misalign}, 32'd0); slot("mis", 1'b1, 32'h4000);

      // Reset during DROP.
      bus.imem_ack = 1'b0; bus.br_valid = 1'b1; bus.br_target = 32'h0000_6000;
      cyc(); bus.br_valid = 1'b0;
      chk("prerst.addr", bus.imem_addr, 32'h4004);
      rst_n = 1'b0;
      #1;
      chk("midrst.req", {31'd0, bus.imem_req}, 32'd0);
      chk("midrst.if_pc", bus.if_pc, 32'd0);
      slot("midrst", 1'b0, 32'd0);
      cyc(); rst_n = 1'b1; bus.imem_ack = 1'b1;
      #0 chk("boot.req", {31'd0, bus.imem_req}, 32'd0);
      cyc(); chk("boot.addr", bus.imem_addr, 32'h3000);

      // PC wrap at the top of the address space.
      bus.br_valid = 1'b1; bus.br_target = 32'hFFFF_FFFC;
      cyc(); bus.br_valid = 1'b0; chk("wrap.addr0", bus.imem_addr, 32'hFFFF_FFFC);
      cyc(); slot("wrap", 1'b1, 32'hFFFF_FFFC); chk("wrap.addr1", bus.imem_addr, 32'h0000_0000);

      // Randomized traffic; the model compare runs every cycle.
      for (int i = 0; i < 3000; i++) begin
         cyc();
         if ($urandom_range(299) == 0) begin
            rst_n = 1'b0;
            cyc();
            rst_n = 1'b1;
         end
         bus.stall    = ($urandom_range(99) < 30);
         bus.imem_ack = ($urandom_range(99) < 60);
         bus.br_valid = ($urandom_range(99) < 8);
         bus.br_target = $urandom;
         if ($urandom_range(3) == 0) bus.br_target = 32'hFFFF_FFF0 | (bus.br_target & 32'hF);
      end
      bus.br_valid = 1'b0;
      repeat (2) cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
